eth_speed_detect_hyst: RTL and testbench

- Parametrised successor to the in-MAC RGMII link-speed detector, running in the tx_clk (125 MHz reference) domain.
- Measures toggle rate of a prescaled rx-clock bit and classifies the link as 10M/100M/1000M.
- Adds configurable window/threshold widths, N-window hysteresis before commit, measurement enable, software force/override, change strobe and validity flag.
- Drives speed and mii_select to the RGMII PHY interface and the MAC core.

---
 rtl/eth_speed_detect_hyst_if.sv | 24 ++
 rtl/eth_speed_detect_hyst.sv | 121 ++++++++++++
 tb/tb_eth_speed_detect_hyst.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_speed_detect_hyst_if.sv
// rtl/eth_speed_detect_hyst_if.sv - control and status bundle of the RGMII link-speed detector
interface eth_speed_detect_hyst_if #(
  parameter int REF_CNT_W = 7
);
  logic                 enable_i;
  logic                 force_en_i;
  logic [1:0]           force_speed_i;
  logic [1:0]           speed_o;
  logic                 mii_select_o;
  logic                 speed_valid_o;
  logic                 speed_change_o;
  logic [REF_CNT_W-1:0] last_ref_cnt_o;

  // master is the detector itself; slave is the MAC/PHY glue that configures it
  modport master (
    input  enable_i, force_en_i, force_speed_i,
    output speed_o, mii_select_o, speed_valid_o, speed_change_o, last_ref_cnt_o
  );

  modport slave (
    output enable_i, force_en_i, force_speed_i,
    input  speed_o, mii_select_o, speed_valid_o, speed_change_o, last_ref_cnt_o
  );
endinterface

// File: rtl/eth_speed_detect_hyst.sv
// rtl/eth_speed_detect_hyst.sv - classifies RGMII link speed from the toggle rate of a prescaled rx clock bit
module eth_speed_detect_hyst #(
  parameter int         SYNC_STAGES = 3,
  parameter int         REF_CNT_W   = 7,
  parameter int         EDGE_CNT_W  = 2,
  parameter int         THRESH_100M = 32,
  parameter int         HYST_COUNT  = 2,
  parameter logic [1:0] RESET_SPEED = 2'b10
) (
  input  logic                    tx_clk,
  input  logic                    gtx_rst,
  input  logic                    rx_toggle_i,
  eth_speed_detect_hyst_if.master ctrl
);

  localparam int                    MATCH_W  = $clog2(HYST_COUNT + 1);
  localparam logic [REF_CNT_W-1:0]  REF_MAX  = '1;
  localparam logic [EDGE_CNT_W-1:0] EDGE_MAX = '1;
  localparam logic [REF_CNT_W-1:0]  THRESH   = REF_CNT_W'(THRESH_100M);
  localparam logic [MATCH_W-1:0]    HYST     = MATCH_W'(HYST_COUNT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [REF_CNT_W-1:0]   ref_cnt;
  logic [EDGE_CNT_W-1:0]  edge_cnt;
  logic [MATCH_W-1:0]     match_cnt;
  logic [1:0]             pend;
  logic [1:0]             speed_q;
  logic                   mii_q;
  logic                   valid_q;
  logic                   change_q;
  logic [REF_CNT_W-1:0]   last_q;

  logic                   rx_edge;
  logic                   close_edge;
  logic                   close_timeout;
  logic                   win_close;
  logic [1:0]             candidate;
  logic [MATCH_W-1:0]     match_next;
  logic                   commit;
  logic [1:0]             force_speed_s;

  always_comb begin
    rx_edge       = sync_q[SYNC_STAGES-1] ^ hist_q;
    // An edge-terminated window outranks a coincident timeout.
    close_edge    = ctrl.enable_i && rx_edge && (edge_cnt == EDGE_MAX);
    close_timeout = ctrl.enable_i && !close_edge && (ref_cnt == REF_MAX);
    win_close     = close_edge || close_timeout;

    candidate = 2'b00;
    if (close_edge) begin
      candidate = (ref_cnt >= THRESH) ? 2'b01 : 2'b10;
    end

    match_next = MATCH_W'(1);
    if (candidate == pend) begin
      match_next = (match_cnt == HYST) ? HYST : match_cnt + MATCH_W'(1);
    end
    commit = win_close && (match_next == HYST);

    force_speed_s = (ctrl.force_speed_i == 2'b11) ? 2'b10 : ctrl.force_speed_i;
  end

  always_ff @(posedge tx_clk or posedge gtx_rst) begin
    if (gtx_rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      ref_cnt   <= '0;
      edge_cnt  <= '0;
      match_cnt <= '0;
      pend      <= 2'b00;
      speed_q   <= RESET_SPEED;
      mii_q     <= (RESET_SPEED != 2'b10);
      valid_q   <= 1'b0;
      change_q  <= 1'b0;
      last_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_toggle_i};
      hist_q   <= sync_q[SYNC_STAGES-1];
      mii_q    <= (speed_q != 2'b10);
      change_q <= 1'b0;

      if (!ctrl.enable_i) begin
        ref_cnt   <= '0;
        edge_cnt  <= '0;
        match_cnt <= '0;
        pend      <= 2'b00;
        valid_q   <= 1'b0;
      end else if (win_close) begin
        ref_cnt   <= '0;
        edge_cnt  <= '0;
        last_q    <= ref_cnt;
        match_cnt <= match_next;
        pend      <= candidate;
        if (commit && !ctrl.force_en_i) begin
          valid_q <= 1'b1;
          if (candidate != speed_q) begin
            speed_q  <= candidate;
            change_q <= 1'b1;
          end
        end
      end else begin
        ref_cnt  <= ref_cnt + REF_CNT_W'(1);
        edge_cnt <= edge_cnt + EDGE_CNT_W'(rx_edge);
      end

      // Override wins over any commit in the same cycle; measurement keeps running underneath.
      if (ctrl.force_en_i) begin
        speed_q  <= force_speed_s;
        change_q <= (force_speed_s != speed_q);
      end
    end
  end

  assign ctrl.speed_o        = speed_q;
  assign ctrl.mii_select_o   = mii_q;
  assign ctrl.speed_valid_o  = valid_q;
  assign ctrl.speed_change_o = change_q;
  assign ctrl.last_ref_cnt_o = last_q;

endmodule

// File: tb/tb_eth_speed_detect_hyst.sv
// tb/tb_eth_speed_detect_hyst.sv - table, hand and random checks of eth_speed_detect_hyst against a window/queue model
module tb_eth_speed_detect_hyst;

  localparam int SYNC    = 3;
  localparam int EDGES   = 4;
  localparam int TIMEOUT = 127;
  localparam int THRESH  = 32;
  localparam logic [1:0] RST_SPEED = 2'b10;

  logic       tx_clk = 1'b0;
  logic       gtx_rst = 1'b1;
  logic       rx = 1'b0;
  logic       en = 1'b0;
  logic       fen = 1'b0;
  logic [1:0] fsp = 2'b00;
  int         half = 0;
  int         tcnt = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         pulses0 = 0;
  int         pulses1 = 0;

  always #4 tx_clk = ~tx_clk;

  eth_speed_detect_hyst_if #(.REF_CNT_W(7)) bus0 ();
  eth_speed_detect_hyst_if #(.REF_CNT_W(7)) bus1 ();

  assign bus0.enable_i      = en;
  assign bus0.force_en_i    = fen;
  assign bus0.force_speed_i = fsp;
  assign bus1.enable_i      = en;
  assign bus1.force_en_i    = fen;
  assign bus1.force_speed_i = fsp;

  eth_speed_detect_hyst #(.HYST_COUNT(2)) dut0 (
    .tx_clk(tx_clk), .gtx_rst(gtx_rst), .rx_toggle_i(rx), .ctrl(bus0)
  );
  eth_speed_detect_hyst #(.HYST_COUNT(1)) dut1 (
    .tx_clk(tx_clk), .gtx_rst(gtx_rst), .rx_toggle_i(rx), .ctrl(bus1)
  );

  // Reference model: window timing in integer cycles, hysteresis as "last N results agree".
  logic       hq [$];
  int         win_cyc, win_edges, m_last;
  logic [1:0] m_speed [2];
  logic       m_mii [2];
  logic       m_valid [2];
  logic       m_change [2];
  logic [1:0] res [2][8];
  int         nres [2];

  function automatic int hyst_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    hq = {};
    repeat (SYNC + 1) hq.push_back(1'b0);
    win_cyc = 0; win_edges = 0; m_last = 0;
    for (int i = 0; i < 2; i++) begin
      m_speed[i] = RST_SPEED; m_mii[i] = (RST_SPEED != 2'b10);
      m_valid[i] = 1'b0; m_change[i] = 1'b0; nres[i] = 0;
    end
  endtask

  function automatic bit agreed(input int i, input logic [1:0] cand);
    if (nres[i] < hyst_of(i)) return 1'b0;
    for (int k = 0; k < hyst_of(i); k++) if (res[i][k] != cand) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic e, cl;
    logic [1:0] cand, fs;
    e = hq[SYNC-1] ^ hq[SYNC];
    hq.push_front(rx);
    void'(hq.pop_back());
    cl = 1'b0; cand = 2'b00;
    if (en) begin
      if (e && win_edges == EDGES - 1) begin
        cl = 1'b1; cand = (win_cyc >= THRESH) ? 2'b01 : 2'b10;
      end else if (win_cyc == TIMEOUT) begin
        cl = 1'b1; cand = 2'b00;
      end
      if (cl) begin
        m_last = win_cyc; win_cyc = 0; win_edges = 0;
      end else begin
        win_cyc++; win_edges += int'(e);
      end
    end else begin
      win_cyc = 0; win_edges = 0;
    end
    fs = (fsp == 2'b11) ? 2'b10 : fsp;
    for (int i = 0; i < 2; i++) begin
      m_mii[i] = (m_speed[i] != 2'b10);
      m_change[i] = 1'b0;
      if (!en) begin
        nres[i] = 0; m_valid[i] = 1'b0;
      end else if (cl) begin
        for (int k = 7; k > 0; k--) res[i][k] = res[i][k-1];
        res[i][0] = cand;
        if (nres[i] < 8) nres[i]++;
        if (agreed(i, cand) && !fen) begin
          m_valid[i] = 1'b1;
          if (cand != m_speed[i]) begin m_speed[i] = cand; m_change[i] = 1'b1; end
        end
      end
      if (fen) begin m_change[i] = (fs != m_speed[i]); m_speed[i] = fs; end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("speed0",  32'(bus0.speed_o),        32'(m_speed[0]));
    check("mii0",    32'(bus0.mii_select_o),   32'(m_mii[0]));
    check("valid0",  32'(bus0.speed_valid_o),  32'(m_valid[0]));
    check("change0", 32'(bus0.speed_change_o), 32'(m_change[0]));
    check("last0",   32'(bus0.last_ref_cnt_o), 32'(m_last));
    check("speed1",  32'(bus1.speed_o),        32'(m_speed[1]));
    check("mii1",    32'(bus1.mii_select_o),   32'(m_mii[1]));
    check("valid1",  32'(bus1.speed_valid_o),  32'(m_valid[1]));
    check("change1", 32'(bus1.speed_change_o), 32'(m_change[1]));
    check("last1",   32'(bus1.last_ref_cnt_o), 32'(m_last));
  endtask

  task automatic tick();
    if (half != 0) begin
      tcnt++;
      if (tcnt >= half) begin rx = ~rx; tcnt = 0; end
    end
    @(posedge tx_clk);
    if (gtx_rst) model_reset(); else model_step();
    @(negedge tx_clk);
    if (bus0.speed_change_o) pulses0++;
    if (bus1.speed_change_o) pulses1++;
    check_outputs();
  endtask

  task automatic toggles(input int n, input int gap);
    half = 0;
    repeat (n) begin
      repeat (gap) tick();
      rx = ~rx;
    end
  endtask

  task automatic hit_reset();
    gtx_rst = 1'b1; rx = 1'b0; half = 0; tcnt = 0;
    model_reset();
    #1;
    check("rst_speed0",  32'(bus0.speed_o),        32'(2'b10));
    check("rst_mii0",    32'(bus0.mii_select_o),   32'(1'b0));
    check("rst_valid0",  32'(bus0.speed_valid_o),  32'(1'b0));
    check("rst_change0", 32'(bus0.speed_change_o), 32'(1'b0));
    check("rst_last0",   32'(bus0.last_ref_cnt_o), 32'(0));
    check("rst_speed1",  32'(bus1.speed_o),        32'(2'b10));
    check("rst_last1",   32'(bus1.last_ref_cnt_o), 32'(0));
    repeat (3) tick();
    gtx_rst = 1'b0;
  endtask

  typedef struct {
    int         half;
    logic       en;
    logic       fen;
    logic [1:0] fsp;
    int         cycles;
    logic [1:0] exp_speed;
    logic       exp_valid;
    int         exp_last;
    int         exp_pulses;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int p0, p1;
    tbl[0]  = '{4,   1'b1, 1'b0, 2'b00, 200, 2'b10, 1'b1, 15,  0};
    tbl[1]  = '{20,  1'b1, 1'b0, 2'b00, 400, 2'b01, 1'b1, 79,  1};
    tbl[2]  = '{200, 1'b1, 1'b0, 2'b00, 700, 2'b00, 1'b1, 127, 1};
    tbl[3]  = '{4,   1'b1, 1'b0, 2'b00, 200, 2'b10, 1'b1, 15,  1};
    tbl[4]  = '{8,   1'b1, 1'b0, 2'b00, 300, 2'b10, 1'b1, 31,  0};
    tbl[5]  = '{9,   1'b1, 1'b0, 2'b00, 300, 2'b01, 1'b1, 35,  1};
    tbl[6]  = '{20,  1'b1, 1'b0, 2'b00, 300, 2'b01, 1'b1, 79,  0};
    tbl[7]  = '{20,  1'b1, 1'b1, 2'b11, 40,  2'b10, 1'b1, 79,  1};
    tbl[8]  = '{20,  1'b1, 1'b0, 2'b00, 300, 2'b01, 1'b1, 79,  1};
    tbl[9]  = '{20,  1'b0, 1'b0, 2'b00, 60,  2'b01, 1'b0, 79,  0};
    tbl[10] = '{4,   1'b1, 1'b0, 2'b00, 200, 2'b10, 1'b1, 15,  1};
    tbl[11] = '{4,   1'b1, 1'b1, 2'b00, 20,  2'b00, 1'b1, 15,  1};
    tbl[12] = '{4,   1'b1, 1'b1, 2'b01, 20,  2'b01, 1'b1, 15,  1};
    tbl[13] = '{4,   1'b1, 1'b0, 2'b00, 200, 2'b10, 1'b1, 15,  1};

    @(negedge tx_clk);
    en = 1'b1;
    hit_reset();

    for (int r = 0; r < 14; r++) begin
      en = tbl[r].en; fen = tbl[r].fen; fsp = tbl[r].fsp; half = tbl[r].half;
      p0 = pulses0;
      repeat (tbl[r].cycles) tick();
      check($sformatf("row%0d_speed", r),  32'(bus0.speed_o),       32'(tbl[r].exp_speed));
      check($sformatf("row%0d_valid", r),  32'(bus0.speed_valid_o), 32'(tbl[r].exp_valid));
      check($sformatf("row%0d_last", r),   32'(bus0.last_ref_cnt_o), 32'(tbl[r].exp_last));
      check($sformatf("row%0d_pulses", r), 32'(pulses0 - p0),       32'(tbl[r].exp_pulses));
    end

    // Reset in the middle of a 100M window must clear everything at once.
    en = 1'b1; fen = 1'b0; half = 20;
    repeat (300) tick();
    check("pre_rst_speed", 32'(bus0.speed_o), 32'(2'b01));
    repeat (30) tick();
    hit_reset();

    // Alternating 100M/1000M windows: HYST 2 never commits, HYST 1 follows every window.
    toggles(8, 4);
    repeat (10) tick();
    p0 = pulses0; p1 = pulses1;
    repeat (4) begin
      toggles(4, 20);
      toggles(4, 4);
    end
    repeat (10) tick();
    check("alt_pulses_h2", 32'(pulses0 - p0), 32'(0));
    check("alt_pulses_h1", 32'(pulses1 - p1), 32'(8));
    check("alt_speed_h2",  32'(bus0.speed_o), 32'(2'b10));
    check("alt_speed_h1",  32'(bus1.speed_o), 32'(2'b10));

    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0:       half = $urandom_range(3, 6);
        1:       half = $urandom_range(7, 10);
        2:       half = $urandom_range(15, 25);
        default: half = $urandom_range(150, 250);
      endcase
      en  = ($urandom_range(0, 9) != 0);
      fen = ($urandom_range(0, 7) == 0);
      fsp = 2'($urandom_range(0, 3));
      repeat ($urandom_range(80, 300)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
